// File: rtl/fifo_read_port_pkg.sv
// Shared definitions for the 8 x 32 FIFO: read-side state encoding, geometry
// constants and the circular pointer increment used by both FIFO controllers.
package fifo_read_port_pkg;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned PTR_W      = 3;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    INIT     = 2'b00,
    NO_OP    = 2'b01,
    READ     = 2'b10,
    RD_ERROR = 2'b11
  } rd_state_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_read_port_mux8_32.sv
// Combinational 8-to-1 word selector in front of the read data register.
module mux8_32
  import fifo_read_port_pkg::*;
(
  input  logic [DATA_W-1:0] d_in0,
  input  logic [DATA_W-1:0] d_in1,
  input  logic [DATA_W-1:0] d_in2,
  input  logic [DATA_W-1:0] d_in3,
  input  logic [DATA_W-1:0] d_in4,
  input  logic [DATA_W-1:0] d_in5,
  input  logic [DATA_W-1:0] d_in6,
  input  logic [DATA_W-1:0] d_in7,
  input  logic [PTR_W-1:0]  sel,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = d_in0;
    unique case (sel)
      3'd0: y = d_in0;
      3'd1: y = d_in1;
      3'd2: y = d_in2;
      3'd3: y = d_in3;
      3'd4: y = d_in4;
      3'd5: y = d_in5;
      3'd6: y = d_in6;
      3'd7: y = d_in7;
      default: y = d_in0;
    endcase
  end

endmodule

// File: rtl/fifo_read_port.sv
// Read side of the 8 x 32 FIFO: read pointer, occupancy count, flags and a
// registered read data word with ack/error status.
//
// state    | meaning
// INIT     | just out of reset, no request seen yet
// NO_OP    | last edge had no read request
// READ     | last edge accepted a read, d_out valid
// RD_ERROR | last edge rejected a read on an empty FIFO
module fifo_read_port
  import fifo_read_port_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic              wr_commit,
  input  logic [DATA_W-1:0] d_in0,
  input  logic [DATA_W-1:0] d_in1,
  input  logic [DATA_W-1:0] d_in2,
  input  logic [DATA_W-1:0] d_in3,
  input  logic [DATA_W-1:0] d_in4,
  input  logic [DATA_W-1:0] d_in5,
  input  logic [DATA_W-1:0] d_in6,
  input  logic [DATA_W-1:0] d_in7,
  output logic [DATA_W-1:0] d_out,
  output logic              rd_ack,
  output logic              rd_err,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic [CNT_W-1:0]  data_count,
  output logic              empty,
  output logic              full
);

  rd_state_e         state_q;
  rd_state_e         state_d;
  logic              rd_accept;
  logic [DATA_W-1:0] rd_word;

  // A write committed at this edge is not yet visible, so acceptance
  // depends only on the registered count.
  assign rd_accept = rd_en && (data_count != '0);

  mux8_32 u_mux (
    .d_in0 (d_in0),
    .d_in1 (d_in1),
    .d_in2 (d_in2),
    .d_in3 (d_in3),
    .d_in4 (d_in4),
    .d_in5 (d_in5),
    .d_in6 (d_in6),
    .d_in7 (d_in7),
    .sel   (rd_ptr),
    .y     (rd_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = NO_OP;
    if (rd_en) begin
      state_d = rd_accept ? READ : RD_ERROR;
    end
  end

  always_comb begin
    rd_ack = 1'b0;
    rd_err = 1'b0;
    unique case (state_q)
      READ:     rd_ack = 1'b1;
      RD_ERROR: rd_err = 1'b1;
      default: begin
        rd_ack = 1'b0;
        rd_err = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_out  <= '0;
      rd_ptr <= '0;
    end else if (rd_accept) begin
      d_out  <= rd_word;
      rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // A commit while full is a write-side violation; the count saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_count <= '0;
    end else begin
      unique case ({rd_accept, wr_commit})
        2'b10: data_count <= data_count - CNT_W'(1);
        2'b01: if (!full) data_count <= data_count + CNT_W'(1);
        default: data_count <= data_count;
      endcase
    end
  end

  assign empty = (data_count == '0);
  assign full  = (data_count == CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_fifo_read_port.sv
// Randomized and directed bench for fifo_read_port against a queue-based FIFO model.
module tb_fifo_read_port;

  logic        clk;
  logic        reset_n;
  logic        rd_en;
  logic        wr_commit;
  logic [31:0] bank [0:7];
  logic [31:0] d_out;
  logic        rd_ack;
  logic        rd_err;
  logic [2:0]  rd_ptr;
  logic [3:0]  data_count;
  logic        empty;
  logic        full;

  int          n_cmp;
  int          n_mis;
  string       phase;

  logic [31:0] q[$];
  int          m_ptr;
  logic [31:0] m_dout;
  logic        m_ack;
  logic        m_err;

  fifo_read_port dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_en      (rd_en),
    .wr_commit  (wr_commit),
    .d_in0      (bank[0]),
    .d_in1      (bank[1]),
    .d_in2      (bank[2]),
    .d_in3      (bank[3]),
    .d_in4      (bank[4]),
    .d_in5      (bank[5]),
    .d_in6      (bank[6]),
    .d_in7      (bank[7]),
    .d_out      (d_out),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .rd_ptr     (rd_ptr),
    .data_count (data_count),
    .empty      (empty),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s.%s: got %h expected %h", phase, tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("d_out", d_out, m_dout);
    chk("rd_ack", 32'(rd_ack), 32'(m_ack));
    chk("rd_err", 32'(rd_err), 32'(m_err));
    chk("rd_ptr", 32'(rd_ptr), 32'(m_ptr));
    chk("data_count", 32'(data_count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 8));
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr  = 0;
    m_dout = '0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
  endtask

  // One clock: drive request, take the edge, then let the bank store the
  // committed word (the bank is a register, so the write lands after the edge).
  task automatic step(input logic r, input logic w, input logic [31:0] wdata);
    int sz;
    int p;
    bit acc;
    rd_en     = r;
    wr_commit = w;
    sz  = q.size();
    p   = m_ptr;
    acc = r && (sz != 0);
    @(posedge clk);
    #1;
    rd_en     = 1'b0;
    wr_commit = 1'b0;
    if (acc) begin
      m_dout = q.pop_front();
      m_ptr  = (m_ptr + 1) % 8;
    end
    m_ack = acc;
    m_err = r && !acc;
    if (w && (sz < 8 || acc)) begin
      bank[(p + sz) % 8] = wdata;
      q.push_back(wdata);
    end
    chk_all();
  endtask

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    rd_en     = 1'b0;
    wr_commit = 1'b0;
    for (int i = 0; i < 8; i++) bank[i] = '0;
    model_reset();

    phase = "por";
    reset_n = 1'b0;
    #1;
    chk_all();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    phase = "rd_empty";
    @(negedge clk);
    step(1'b1, 1'b0, '0);
    chk("d_out_zero", d_out, 32'h0);
    chk("err_set", 32'(rd_err), 32'd1);
    step(1'b0, 1'b0, '0);

    phase = "fill";
    for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, 32'h1111_1111 * k);
    chk("full_set", 32'(full), 32'd1);
    chk("count8", 32'(data_count), 32'd8);

    phase = "drain";
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, '0);
      chk("data", d_out, 32'h1111_1111 * k);
      chk("ack", 32'(rd_ack), 32'd1);
    end
    chk("empty_end", 32'(empty), 32'd1);
    chk("ptr_wrap", 32'(rd_ptr), 32'd0);

    phase = "overflow";
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 32'hB000_0000 + k);
    step(1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("count_sat", 32'(data_count), 32'd8);
    chk("ptr_hold", 32'(rd_ptr), 32'd0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, '0);
    chk("last_word", d_out, 32'hB000_0007);

    phase = "rd_wr";
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'hC000_0000 + k);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 32'hC100_0000 + k);
      chk("ack", 32'(rd_ack), 32'd1);
      chk("count3", 32'(data_count), 32'd3);
    end
    chk("ptr_plus4", 32'(rd_ptr), 32'd4);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, '0);

    phase = "wrap";
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 32'h5000_0000 + k);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, '0);
    chk("ptr6", 32'(rd_ptr), 32'd6);
    step(1'b0, 1'b1, 32'hA000_0006);
    step(1'b0, 1'b1, 32'hA000_0007);
    step(1'b0, 1'b1, 32'hA000_0000);
    step(1'b1, 1'b0, '0);
    chk("e6", d_out, 32'hA000_0006);
    step(1'b1, 1'b0, '0);
    chk("e7", d_out, 32'hA000_0007);
    step(1'b1, 1'b0, '0);
    chk("e0", d_out, 32'hA000_0000);
    chk("ptr1", 32'(rd_ptr), 32'd1);

    phase = "rw_empty";
    step(1'b1, 1'b1, 32'hCAFE_0001);
    chk("err", 32'(rd_err), 32'd1);
    chk("count1", 32'(data_count), 32'd1);
    chk("not_empty", 32'(empty), 32'd0);
    step(1'b1, 1'b0, '0);
    chk("ack", 32'(rd_ack), 32'd1);
    chk("data", d_out, 32'hCAFE_0001);

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    phase = "mid_reset";
    while (q.size() == 0) step(1'b0, 1'b1, $urandom);
    step(1'b1, 1'b0, '0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_all();
    @(negedge clk);
    reset_n = 1'b1;

    phase = "post_reset";
    for (int n = 0; n < 100; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
